// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared ALU definitions: default operand width and multiplier state encoding.
package seq_shift_add_multiplier_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_t;

endpackage : seq_shift_add_multiplier_pkg

// File: rtl/shift_right.sv
// Single-bit logical right shifter: inserts a caller-supplied MSB and
// exposes the bit that falls off the LSB end.
module shift_right #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_new_msb,
  output logic [WIDTH-1:0] o_data,
  output logic             o_shifted_lsb
);

  assign o_data        = {i_new_msb, i_data[WIDTH-1:1]};
  assign o_shifted_lsb = i_data[0];

endmodule : shift_right

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier. One iteration per clock:
// conditionally add the multiplicand into the high half, then shift the
// {carry, hi, lo} chain right by one through two shift_right instances.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  mult_state_t      r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH:0]   w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;
  logic             w_hi_shifted_lsb;
  logic             w_lo_unused_lsb;

  // Select the multiplicand when the current multiplier bit is set, else add nothing.
  always_comb begin
    w_addend = {(WIDTH + 1){1'b0}};
    if (r_lo[0]) begin
      w_addend = {1'b0, r_mcand};
    end else begin
      w_addend = {(WIDTH + 1){1'b0}};
    end
  end

  // WIDTH+1-bit add keeps the carry so it can re-enter as the shifted-in MSB.
  assign w_sum = {1'b0, r_hi} + w_addend;

  shift_right #(.WIDTH(WIDTH)) u_shift_hi (
    .i_data        (w_sum[WIDTH-1:0]),
    .i_new_msb     (w_sum[WIDTH]),
    .o_data        (w_hi_next),
    .o_shifted_lsb (w_hi_shifted_lsb)
  );

  // The bit leaving the low half is the multiplier bit just consumed; it is not needed.
  shift_right #(.WIDTH(WIDTH)) u_shift_lo (
    .i_data        (r_lo),
    .i_new_msb     (w_hi_shifted_lsb),
    .o_data        (w_lo_next),
    .o_shifted_lsb (w_lo_unused_lsb)
  );

  // Control FSM and datapath registers; busy/done are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mcand <= {WIDTH{1'b0}};
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
      r_count <= {CNT_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= A;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= B;
            r_count <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_hi    <= w_hi_next;
          r_lo    <= w_lo_next;
          r_count <= r_count + CNT_ONE;
          if (r_count == LAST_CNT) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign product_hi = r_hi;
  assign product_lo = r_lo;

endmodule : seq_shift_add_multiplier

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: directed corner cases
// plus random operands, checked against a plain 64-bit multiply.
module tb_seq_shift_add_multiplier;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;

  int n_checks = 0;
  int n_errors = 0;

  seq_shift_add_multiplier dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .product_hi (product_hi),
    .product_lo (product_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  // mode 0: plain operation; mode 1: extra start pulse at RUN cycle 'at';
  // mode 2: reset asserted at RUN cycle 'at'.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input int at);
    int          busy_cnt;
    int          done_cnt;
    int          done_at;
    logic [63:0] exp;
    exp      = ref_mul(a, b);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = 0;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = cyc;
        if (mode != 2) check_eq({tag, "_prod_at_done"}, {product_hi, product_lo}, exp);
      end
      if (mode == 1 && cyc == at) begin
        A     = 32'd1;
        B     = 32'd1;
        start = 1'b1;
      end else if (mode == 1 && cyc == at + 1) begin
        start = 1'b0;
      end
      if (mode == 2 && cyc == at) begin
        reset = 1'b1;
        #1;
        check_eq({tag, "_rst_busy"}, {63'd0, busy}, 64'd0);
        check_eq({tag, "_rst_done"}, {63'd0, done}, 64'd0);
        check_eq({tag, "_rst_prod"}, {product_hi, product_lo}, 64'd0);
      end else if (mode == 2 && cyc == at + 1) begin
        reset = 1'b0;
      end
      @(negedge clk);
    end
    if (mode == 2) begin
      check_eq({tag, "_no_done"}, 64'(done_cnt), 64'd0);
      check_eq({tag, "_prod_after"}, {product_hi, product_lo}, 64'd0);
    end else begin
      check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
      check_eq({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      check_eq({tag, "_done_latency"}, 64'(done_at), 64'd33);
      check_eq({tag, "_prod_hold"}, {product_hi, product_lo}, exp);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] exp_hold;
    reset = 1'b1;
    start = 1'b0;
    A     = 32'd0;
    B     = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", {63'd0, busy}, 64'd0);
    check_eq("reset_done", {63'd0, done}, 64'd0);
    check_eq("reset_prod", {product_hi, product_lo}, 64'd0);

    // start while reset is held must not launch an operation
    A     = 32'd9;
    B     = 32'd9;
    start = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_wins_busy", {63'd0, busy}, 64'd0);
    check_eq("reset_wins_prod", {product_hi, product_lo}, 64'd0);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_op("a3b5",      32'd3,          32'd5,          0, 0);
    run_op("ffxff",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0);
    run_op("bzero",     32'h1234_5678,  32'd0,          0, 0);
    run_op("azero",     32'd0,          32'hDEAD_BEEF,  0, 0);
    run_op("ignore_st", 32'd7,          32'd9,          1, 10);
    run_op("abort",     32'h0001_0000,  32'h0001_0000,  2, 15);
    run_op("after_rst", 32'd2,          32'd3,          0, 0);
    run_op("msb_x2",    32'h8000_0000,  32'd2,          0, 0);

    exp_hold = ref_mul(32'h8000_0000, 32'd2);
    repeat (5) @(negedge clk);
    check_eq("idle_hold5", {product_hi, product_lo}, exp_hold);
    check_eq("idle_busy",  {63'd0, busy}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 0) ra = 32'hFFFF_FFFF;
      if (i == 1) rb = 32'h8000_0001;
      run_op($sformatf("rand%0d", i), ra, rb, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_shift_add_multiplier
